bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter sharing the single data-bus port into the address-decode bridge (DM, TC1, TC2, interrupt range).
- Master 0 is the CPU memory stage; master 1 is a DMA/debug master.
- Each access is serialised into a fixed 3-cycle transaction: arbitrate, drive slave, respond.
- Round-robin arbitration with a bounded lock option for master 1 bursts.

Parameters:
MAX_LOCK, 4, max consecutive locked grants to M1 while M0 is requesting (1..15)
LOCK_W, 4, width of lock counter; must hold MAX_LOCK

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
m0_req  input  1  M0 request; held high with stable addr/wdata/byteen until m0_ack
m0_addr  input  32  M0 byte address
m0_wdata  input  32  M0 write data
m0_byteen  input  4  M0 byte enables; nonzero = write, 0 = read
m0_rdata  output  32  read data to M0, valid when m0_ack=1
m0_ack  output  1  one-cycle completion pulse to M0
m1_req  input  1  M1 request, same rules as M0
m1_lock  input  1  M1 asks to keep the bus for its next request
m1_addr  input  32  M1 byte address
m1_wdata  input  32  M1 write data
m1_byteen  input  4  M1 byte enables
m1_rdata  output  32  read data to M1, valid when m1_ack=1
m1_ack  output  1  one-cycle completion pulse to M1
s_addr  output  32  address to bridge
s_wdata  output  32  write data to bridge
s_byteen  output  4  byte enables to bridge; nonzero only in BUSY
s_rdata  input  32  combinational read data from bridge for current s_addr
busy  output  1  high in BUSY and RESP
owner  output  1  master of the current or last transaction

Behaviour:
- Async reset (reset=0) sets every output to 0 and state to IDLE. It also sets last_grant=1, so M0 wins the first tie, and lock_cnt=0.
- States:
  - IDLE: arbitrate.
  - BUSY: slave port driven.
  - RESP: ack issued.
- All outputs are registered; no combinational path from any input to any output.
- IDLE, no request: stay in IDLE; s_byteen=0, ack=0.
- IDLE, single requester: grant it.
- IDLE, both requesting, normal case: grant the master != last_grant.
- Lock override, checked first:
  - Condition: last_grant=1, M1's previous transaction had m1_lock=1, m1_req=1, and lock_cnt<MAX_LOCK.
  - Result: grant M1 regardless of M0.
- On grant, at the clock edge:
  - s_addr, s_wdata and s_byteen are loaded from the winner.
  - owner=last_grant=winner; state moves to BUSY.
- lock_cnt:
  - Increments when M1 is granted via the lock override while m0_req=1.
  - Clears to 0 on any M0 grant, or on any M1 grant with m1_lock=0.
  - Saturates at MAX_LOCK.
- BUSY (exactly 1 cycle):
  - The bridge sees stable s_*; its write takes effect at this cycle's edge.
  - s_rdata is captured into the owner's rdata register.
  - The non-owner's rdata holds its old value.
  - Next state is RESP.
- RESP (exactly 1 cycle):
  - s_byteen=0, s_addr/s_wdata hold their values.
  - owner's ack=1 and rdata is valid; next state is IDLE.
  - Requests sampled in RESP are ignored. The acked master drops req at the next edge, or keeps it high for a new transaction.
- Latency: req first sampled in IDLE at edge N → BUSY in cycle N+1 → ack in cycle N+2. Throughput is at most 1 transaction per 3 cycles.
- Read and write use identical timing; rdata on a write ack is don't-care but deterministic (captured s_rdata).
- The losing master waits with req held and is served next IDLE, except under a valid lock. M0 waits at most MAX_LOCK+1 transactions.
- m1_lock with m1_req=0: no effect, lock_cnt clears.
- Reset asserted in BUSY or RESP: immediate return to IDLE with all outputs 0. No ack is issued for the aborted transaction; the master must reissue. A write already committed at a prior edge stays committed.
- m0_ack and m1_ack are never high together; ack never asserts without a prior grant.

Test Plan:
- Reset release, then m0_req read of 0x0000_3000 with s_rdata=0xDEAD_BEEF → s_addr=0x3000 and s_byteen=0 in cycle N+1; m0_ack=1 and m0_rdata=0xDEAD_BEEF in cycle N+2; busy=0 in N+3.
- M0 write of 0x7F00, byteen=4'b1111, wdata=0x1234 → s_byteen=4'b1111 only in the single BUSY cycle, 0 in IDLE and RESP; m0_ack in N+2.
- m0_req and m1_req rise together after reset → M0 granted first (owner=0), M1 served in the next IDLE; both held continuously → grants alternate 0,1,0,1.
- m1_lock=1 and m0_req=1 throughout, MAX_LOCK=4 → M1 granted 5 consecutive times (1 normal, 4 locked), then M0 granted; lock_cnt returns to 0.
- reset pulsed low mid-BUSY of an M1 read → all outputs 0 asynchronously; no m1_ack; with M0 and M1 re-requesting after release, M0 wins.
- m1_lock=1 with m1_req=0 and m0_req=1 → M0 granted, lock_cnt=0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the address-decode bridge.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface bus_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [BW-1:0] m0_byteen;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;

  logic          m1_req;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [BW-1:0] m1_byteen;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;

  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [BW-1:0] s_byteen;
  logic [DW-1:0] s_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_byteen,
    input  m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen,
    input  s_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output s_addr, s_wdata, s_byteen, busy, owner
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_byteen,
    output m1_req, m1_lock, m1_addr, m1_wdata, m1_byteen,
    output s_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  s_addr, s_wdata, s_byteen, busy, owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto the bridge data port; each access is a fixed
// arbitrate / drive-slave / respond sequence, with a bounded lock for M1 bursts.
module bus_arbiter #(
  parameter int unsigned MAX_LOCK = 4,
  parameter int unsigned LOCK_W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] byteen;
  } slv_req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  slv_req_t          slv_q, slv_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              lock_prev_q, lock_prev_d;
  logic              busy_q, busy_d;
  logic [1:0]        ack_q, ack_d;
  logic [DW-1:0]     rdata0_q, rdata0_d;
  logic [DW-1:0]     rdata1_q, rdata1_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic              lock_ok_c;
  logic              winner_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      slv_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_prev_q  <= 1'b0;
      busy_q       <= 1'b0;
      ack_q        <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      lock_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      slv_q        <= slv_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_prev_q  <= lock_prev_d;
      busy_q       <= busy_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slv_d        = slv_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_prev_d  = lock_prev_q;
    busy_d       = busy_q;
    ack_d        = '0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    lock_cnt_d   = lock_cnt_q;

    // Lock override wins over round-robin while the burst budget lasts.
    lock_ok_c = last_grant_q && lock_prev_q && bus.m1_req &&
                (lock_cnt_q < LOCK_W'(MAX_LOCK));
    if (lock_ok_c)                     winner_c = 1'b1;
    else if (bus.m0_req && bus.m1_req) winner_c = ~last_grant_q;
    else                               winner_c = bus.m1_req;

    case (state_q)
      IDLE: begin
        if (!bus.m1_req) lock_cnt_d = '0;
        if (bus.m0_req || bus.m1_req) begin
          state_d      = BUSY;
          busy_d       = 1'b1;
          owner_d      = winner_c;
          last_grant_d = winner_c;
          if (winner_c) begin
            slv_d       = {bus.m1_addr, bus.m1_wdata, bus.m1_byteen};
            lock_prev_d = bus.m1_lock;
            if (!bus.m1_lock)                 lock_cnt_d = '0;
            else if (lock_ok_c && bus.m0_req) lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end else begin
            slv_d       = {bus.m0_addr, bus.m0_wdata, bus.m0_byteen};
            lock_prev_d = 1'b0;
            lock_cnt_d  = '0;
          end
        end
      end
      BUSY: begin
        state_d      = RESP;
        slv_d.byteen = '0;
        ack_d        = owner_q ? 2'b10 : 2'b01;
        if (owner_q) rdata1_d = bus.s_rdata;
        else         rdata0_d = bus.s_rdata;
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_addr   = slv_q.addr;
  assign bus.s_wdata  = slv_q.wdata;
  assign bus.s_byteen = slv_q.byteen;
  assign bus.m0_ack   = ack_q[0];
  assign bus.m1_ack   = ack_q[1];
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.busy     = busy_q;
  assign bus.owner    = owner_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a directed vector table, hand sequences for lock bursts and
// mid-transaction reset, then random traffic against a transaction-level reference model.
module tb_bus_arbiter;
  localparam int MAX_LOCK = 4;
  localparam int NV       = 20;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  bus_arbiter_if bus();

  bus_arbiter #(.MAX_LOCK(MAX_LOCK), .LOCK_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bridge stand-in: one fixed word, otherwise an address-derived pattern.
  function automatic logic [31:0] bridge(input logic [31:0] a);
    return (a == 32'h0000_3000) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
  endfunction

  assign bus.s_rdata = bridge(bus.s_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_busy, input logic e_owner,
                         input logic [31:0] e_addr, input logic [31:0] e_wd,
                         input logic [3:0] e_be, input logic e_a0, input logic e_a1,
                         input logic [31:0] e_r0, input logic [31:0] e_r1);
    chk({tag, ".busy"},     32'(bus.busy),     32'(e_busy));
    chk({tag, ".owner"},    32'(bus.owner),    32'(e_owner));
    chk({tag, ".s_addr"},   bus.s_addr,        e_addr);
    chk({tag, ".s_wdata"},  bus.s_wdata,       e_wd);
    chk({tag, ".s_byteen"}, 32'(bus.s_byteen), 32'(e_be));
    chk({tag, ".m0_ack"},   32'(bus.m0_ack),   32'(e_a0));
    chk({tag, ".m1_ack"},   32'(bus.m1_ack),   32'(e_a1));
    chk({tag, ".m0_rdata"}, bus.m0_rdata,      e_r0);
    chk({tag, ".m1_rdata"}, bus.m1_rdata,      e_r1);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [3:0]  m0_be;
    logic        m1_req;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic        e_busy;
    logic        e_owner;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_be;
    logic        e_a0;
    logic        e_a1;
    logic [31:0] e_r0;
    logic [31:0] e_r1;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic m0r, input logic [31:0] m0a, input logic [3:0] m0b,
                              input logic m1r, input logic m1l, input logic [31:0] m1a,
                              input logic eb, input logic eo, input logic [31:0] ea,
                              input logic [31:0] ew, input logic [3:0] ebe, input logic ea0,
                              input logic ea1, input logic [31:0] er0, input logic [31:0] er1);
    vec_t v;
    v.m0_req = m0r; v.m0_addr = m0a; v.m0_be = m0b;
    v.m1_req = m1r; v.m1_lock = m1l; v.m1_addr = m1a;
    v.e_busy = eb; v.e_owner = eo; v.e_addr = ea; v.e_wd = ew; v.e_be = ebe;
    v.e_a0 = ea0; v.e_a1 = ea1; v.e_r0 = er0; v.e_r1 = er1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int          m_left;      // cycles left in the transaction in flight
  logic        m_last;      // master granted most recently
  logic        m_prev_lock; // M1's last granted request asked for lock
  int          m_streak;    // locked grants to M1 taken over a waiting M0
  logic        m_busy, m_owner, m_ack0, m_ack1;
  logic [31:0] m_addr, m_wd, m_rd0, m_rd1;
  logic [3:0]  m_be;

  task automatic model_reset();
    m_left = 0; m_last = 1'b1; m_prev_lock = 1'b0; m_streak = 0;
    m_busy = 0; m_owner = 0; m_ack0 = 0; m_ack1 = 0;
    m_addr = '0; m_wd = '0; m_rd0 = '0; m_rd1 = '0; m_be = '0;
  endtask

  task automatic model_step();
    logic w;
    logic locked;
    if (m_left == 0) begin
      if (!bus.m1_req) m_streak = 0;
      if (bus.m0_req || bus.m1_req) begin
        locked = m_last && m_prev_lock && bus.m1_req && (m_streak < MAX_LOCK);
        w = locked ? 1'b1 : ((bus.m0_req && bus.m1_req) ? !m_last : bus.m1_req);
        m_owner = w; m_last = w; m_busy = 1'b1; m_left = 2;
        if (w) begin
          m_addr = bus.m1_addr; m_wd = bus.m1_wdata; m_be = bus.m1_byteen;
          m_prev_lock = bus.m1_lock;
          if (!bus.m1_lock) m_streak = 0;
          else if (locked && bus.m0_req) m_streak++;
        end else begin
          m_addr = bus.m0_addr; m_wd = bus.m0_wdata; m_be = bus.m0_byteen;
          m_prev_lock = 1'b0; m_streak = 0;
        end
      end
    end else if (m_left == 2) begin
      m_be = '0;
      if (m_owner) begin m_ack1 = 1'b1; m_rd1 = bridge(m_addr); end
      else         begin m_ack0 = 1'b1; m_rd0 = bridge(m_addr); end
      m_left = 1;
    end else begin
      m_ack0 = 0; m_ack1 = 0; m_busy = 0; m_left = 0;
    end
  endtask

  task automatic new_m0();
    bus.m0_addr   = $urandom;
    bus.m0_wdata  = $urandom;
    bus.m0_byteen = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
  endtask

  task automatic new_m1();
    bus.m1_addr   = $urandom;
    bus.m1_wdata  = $urandom;
    bus.m1_byteen = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
    bus.m1_lock   = ($urandom_range(3) != 0);
  endtask

  // Masters hold requests until acked, then drop or reissue.
  task automatic drive_random();
    if (bus.m0_req) begin
      if (m_ack0) begin
        if ($urandom_range(1) == 0) bus.m0_req = 1'b0;
        else new_m0();
      end
    end else if ($urandom_range(2) != 0) begin
      bus.m0_req = 1'b1; new_m0();
    end
    if (bus.m1_req) begin
      if (m_ack1) begin
        if ($urandom_range(1) == 0) bus.m1_req = 1'b0;
        else new_m1();
      end
    end else if ($urandom_range(2) != 0) begin
      bus.m1_req = 1'b1; new_m1();
    end else begin
      bus.m1_lock = 1'($urandom_range(1));
    end
  endtask

  task automatic wait_grant(output logic ok, output logic who);
    logic prev;
    prev = bus.busy; ok = 1'b0; who = 1'b0;
    for (int c = 0; c < 12 && !ok; c++) begin
      cycle();
      if (bus.busy && !prev) begin ok = 1'b1; who = bus.owner; end
      prev = bus.busy;
    end
  endtask

  initial begin
    logic        ok, who;
    logic        prev_busy;
    int          m0_waits;
    bit          exp_seq [12];
    logic [31:0] A, B, W, C, R0, R1, RW, RC;

    n_tests = 0; n_fail = 0;
    A = 32'h0000_3000; B = 32'h0000_0200; W = 32'h0000_7F00; C = 32'h0000_0040;
    R0 = 32'hDEAD_BEEF; R1 = 32'h0200_FDFF; RW = 32'h7F00_80FF; RC = 32'h0040_FFBF;

    vecs[0]  = mk(0, 0, 4'h0, 0, 0, 0,  0, 0, 0, 0,             4'h0, 0, 0, 0,  0);
    vecs[1]  = mk(1, A, 4'h0, 1, 0, B,  1, 0, A, 32'h1234, 4'h0, 0, 0, 0,  0);
    vecs[2]  = mk(1, A, 4'h0, 1, 0, B,  1, 0, A, 32'h1234, 4'h0, 1, 0, R0, 0);
    vecs[3]  = mk(1, A, 4'h0, 1, 0, B,  0, 0, A, 32'h1234, 4'h0, 0, 0, R0, 0);
    vecs[4]  = mk(1, A, 4'h0, 1, 0, B,  1, 1, B, 32'h5678, 4'h0, 0, 0, R0, 0);
    vecs[5]  = mk(1, A, 4'h0, 1, 0, B,  1, 1, B, 32'h5678, 4'h0, 0, 1, R0, R1);
    vecs[6]  = mk(1, A, 4'h0, 1, 0, B,  0, 1, B, 32'h5678, 4'h0, 0, 0, R0, R1);
    vecs[7]  = mk(1, A, 4'h0, 1, 0, B,  1, 0, A, 32'h1234, 4'h0, 0, 0, R0, R1);
    vecs[8]  = mk(1, A, 4'h0, 1, 0, B,  1, 0, A, 32'h1234, 4'h0, 1, 0, R0, R1);
    vecs[9]  = mk(1, A, 4'h0, 1, 0, B,  0, 0, A, 32'h1234, 4'h0, 0, 0, R0, R1);
    vecs[10] = mk(1, A, 4'h0, 1, 0, B,  1, 1, B, 32'h5678, 4'h0, 0, 0, R0, R1);
    vecs[11] = mk(1, A, 4'h0, 1, 0, B,  1, 1, B, 32'h5678, 4'h0, 0, 1, R0, R1);
    vecs[12] = mk(0, 0, 4'h0, 0, 0, 0,  0, 1, B, 32'h5678, 4'h0, 0, 0, R0, R1);
    vecs[13] = mk(1, W, 4'hF, 0, 0, 0,  1, 0, W, 32'h1234, 4'hF, 0, 0, R0, R1);
    vecs[14] = mk(1, W, 4'hF, 0, 0, 0,  1, 0, W, 32'h1234, 4'h0, 1, 0, RW, R1);
    vecs[15] = mk(0, 0, 4'h0, 0, 0, 0,  0, 0, W, 32'h1234, 4'h0, 0, 0, RW, R1);
    vecs[16] = mk(1, C, 4'h0, 0, 1, 0,  1, 0, C, 32'h1234, 4'h0, 0, 0, RW, R1);
    vecs[17] = mk(1, C, 4'h0, 0, 1, 0,  1, 0, C, 32'h1234, 4'h0, 1, 0, RC, R1);
    vecs[18] = mk(0, 0, 4'h0, 0, 1, 0,  0, 0, C, 32'h1234, 4'h0, 0, 0, RC, R1);
    vecs[19] = mk(0, 0, 4'h0, 0, 0, 0,  0, 0, C, 32'h1234, 4'h0, 0, 0, RC, R1);

    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    bus.m0_req = 0; bus.m0_addr = '0; bus.m0_wdata = 32'h1234; bus.m0_byteen = '0;
    bus.m1_req = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = 32'h5678; bus.m1_byteen = '0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      bus.m0_req = vecs[i].m0_req; bus.m0_addr = vecs[i].m0_addr; bus.m0_byteen = vecs[i].m0_be;
      bus.m1_req = vecs[i].m1_req; bus.m1_lock = vecs[i].m1_lock; bus.m1_addr = vecs[i].m1_addr;
      cycle();
      chk_out($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_owner, vecs[i].e_addr,
              vecs[i].e_wd, vecs[i].e_be, vecs[i].e_a0, vecs[i].e_a1, vecs[i].e_r0, vecs[i].e_r1);
    end

    // Locked M1 burst against a continuously waiting M0.
    bus.m0_req = 1; bus.m0_addr = 32'h10; bus.m0_byteen = '0;
    bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h20; bus.m1_byteen = '0;
    for (int g = 0; g < 12; g++) begin
      wait_grant(ok, who);
      chk($sformatf("lock_grant%0d_seen", g), 32'(ok), 32'd1);
      chk($sformatf("lock_grant%0d_owner", g), 32'(who), 32'(exp_seq[g]));
    end
    bus.m0_req = 0; bus.m1_req = 0; bus.m1_lock = 0;
    repeat (3) cycle();

    // Reset asserted while an M1 read is in its slave cycle.
    bus.m1_req = 1; bus.m1_addr = 32'h80;
    cycle();
    chk("rst_pre.busy", 32'(bus.busy), 32'd1);
    chk("rst_pre.owner", 32'(bus.owner), 32'd1);
    reset = 1'b0;
    #1;
    chk_out("rst_async", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    @(negedge clk);
    chk_out("rst_hold", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    bus.m0_req = 1; bus.m0_addr = 32'h90;
    reset = 1'b1;
    cycle();
    chk_out("post_rst_grant", 1, 0, 32'h90, 32'h1234, 4'h0, 0, 0, 0, 0);
    cycle();
    chk_out("post_rst_ack", 1, 0, 32'h90, 32'h1234, 4'h0, 1, 0, 32'h0090_FF6F, 0);
    bus.m0_req = 0;
    cycle();
    chk_out("post_rst_idle", 0, 0, 32'h90, 32'h1234, 4'h0, 0, 0, 32'h0090_FF6F, 0);
    cycle();
    chk_out("m1_reissue", 1, 1, 32'h80, 32'h5678, 4'h0, 0, 0, 32'h0090_FF6F, 0);
    bus.m1_req = 0;
    repeat (3) cycle();

    // Random traffic against the reference model.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    model_reset();
    prev_busy = 1'b0;
    m0_waits = 0;
    for (int cy = 0; cy < 4000 && n_fail < 40; cy++) begin
      chk_out("rnd", m_busy, m_owner, m_addr, m_wd, m_be, m_ack0, m_ack1, m_rd0, m_rd1);
      if (bus.busy && !prev_busy) begin
        if (bus.owner) begin
          if (bus.m0_req) m0_waits++;
        end else begin
          chk("m0_wait_bound", 32'(m0_waits <= MAX_LOCK + 1), 32'd1);
          m0_waits = 0;
        end
      end
      prev_busy = bus.busy;
      drive_random();
      model_step();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
